// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive frame controller and its edge/bit counter,
// data sampler and consumer. Error-counter ports exist only with UART_RX_ERR_CNT_EN.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [5:0]            edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  sampled_bit;
    logic                  cnt_enable;
    logic                  dat_samp_en;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]            par_err_cnt;
    logic [7:0]            stp_err_cnt;
`endif

    // Frame controller side.
    modport master (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt, sampled_bit,
        output cnt_enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
`ifdef UART_RX_ERR_CNT_EN
        , output par_err_cnt, stp_err_cnt
`endif
    );

    // Counter/sampler/consumer side.
    modport slave (
        output RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt, sampled_bit,
        input  cnt_enable, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
`ifdef UART_RX_ERR_CNT_EN
        , input par_err_cnt, stp_err_cnt
`endif
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: START/DATA/PARITY/STOP sequencing, LSB-first
// deserialisation and error strobes. UART_RX_ERR_CNT_EN adds saturating error counters.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_fsm_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  strt_glitch_q;
    logic                  frame_err_q;

    logic bit_end;
    logic parity_exp;

    assign bit_end    = (state_q != IDLE) && (bus.edge_cnt == bus.Prescale);
    assign parity_exp = bus.PAR_TYP ? ~^shift_q : ^shift_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle; a later non-blocking write in the
            // case below wins, giving exactly one cycle high after the bit end.
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            case (state_q)
                IDLE: if (!bus.RX_IN) state_q <= START;
                START: if (bit_end) begin
                    if (bus.sampled_bit) begin
                        strt_glitch_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (bit_end) begin
                    shift_q <= {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bus.bit_cnt == 4'(DATA_WIDTH))
                        state_q <= bus.PAR_EN ? PARITY : STOP;
                end
                PARITY: if (bit_end) begin
                    if (bus.sampled_bit != parity_exp) begin
                        frame_err_q <= 1'b1;
                        par_err_q   <= 1'b1;
                    end
                    state_q <= STOP;
                end
                STOP: if (bit_end) begin
                    if (!bus.sampled_bit) begin
                        stp_err_q <= 1'b1;
                    end else if (!frame_err_q) begin
                        p_data_q     <= shift_q;
                        data_valid_q <= 1'b1;
                    end
                    frame_err_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cnt_enable  = (state_q != IDLE);
    assign bus.dat_samp_en = (state_q != IDLE);
    assign bus.P_DATA      = p_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.strt_glitch = strt_glitch_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] par_err_cnt_q;
    logic [7:0] stp_err_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt_q <= '0;
            stp_err_cnt_q <= '0;
        end else begin
            if (par_err_q && (par_err_cnt_q != 8'hFF)) par_err_cnt_q <= par_err_cnt_q + 8'd1;
            if (stp_err_q && (stp_err_cnt_q != 8'hFF)) stp_err_cnt_q <= stp_err_cnt_q + 8'd1;
        end
    end

    assign bus.par_err_cnt = par_err_cnt_q;
    assign bus.stp_err_cnt = stp_err_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: the bench plays the edge/bit counter and sampler,
// walking hand-built frames and checking strobes and P_DATA against fixed values.
module tb_uart_rx_fsm;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    int   dv_n, pe_n, se_n, sg_n;

    uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe-cycle counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (bus.data_valid)  dv_n++;
        if (bus.par_err)     pe_n++;
        if (bus.stp_err)     se_n++;
        if (bus.strt_glitch) sg_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        dv_n = 0; pe_n = 0; se_n = 0; sg_n = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Start edge, then n_bits bits of Prescale ticks each: start, data LSB first,
    // optional parity, stop. Leaves the bench in the cycle after the last bit end.
    task automatic play(input logic [7:0] data, input logic par_en, input logic par_bit,
                        input logic stop_bit, input logic start_bit, input int n_bits);
        logic v;
        int   pre;
        pre         = int'(bus.Prescale);
        bus.RX_IN   = 1'b0;
        bus.PAR_EN  = par_en;
        bus.edge_cnt = 6'd1;
        bus.bit_cnt  = 4'd0;
        next_cycle();
        check("cnt_enable_in_frame", bus.cnt_enable, 1);
        check("dat_samp_en_in_frame", bus.dat_samp_en, 1);
        bus.RX_IN = 1'b1;
        for (int b = 0; b < n_bits; b++) begin
            if (b == 0)                 v = start_bit;
            else if (b <= 8)            v = data[b-1];
            else if (b == 9 && par_en)  v = par_bit;
            else                        v = stop_bit;
            for (int e = 1; e <= pre; e++) begin
                bus.bit_cnt     = 4'(b);
                bus.edge_cnt    = 6'(e);
                bus.sampled_bit = v;
                next_cycle();
            end
        end
        bus.edge_cnt    = 6'd1;
        bus.bit_cnt     = 4'd0;
        bus.sampled_bit = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int dv, input int pe, input int se,
                               input int sg, input logic [7:0] pdata);
        next_cycle();
        check({tag, "_data_valid_cycles"}, dv_n, dv);
        check({tag, "_par_err_cycles"}, pe_n, pe);
        check({tag, "_stp_err_cycles"}, se_n, se);
        check({tag, "_strt_glitch_cycles"}, sg_n, sg);
        check({tag, "_P_DATA"}, bus.P_DATA, pdata);
        check({tag, "_cnt_enable_idle"}, bus.cnt_enable, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_counts();
        RST             = 1'b0;
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.PAR_TYP     = 1'b0;
        bus.Prescale    = 6'd8;
        bus.edge_cnt    = 6'd1;
        bus.bit_cnt     = 4'd0;
        bus.sampled_bit = 1'b0;
        next_cycle();
        next_cycle();
        check("rst_cnt_enable", bus.cnt_enable, 0);
        check("rst_dat_samp_en", bus.dat_samp_en, 0);
        check("rst_P_DATA", bus.P_DATA, 0);
        check("rst_strobes", {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch}, 0);
        RST = 1'b1;
        next_cycle();
        check("idle_no_enable", bus.cnt_enable, 0);

        // 1: Prescale 8, no parity, 0xA5.
        clear_counts();
        play(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        check("t1_dv_after_bit_end", bus.data_valid, 1);
        check("t1_P_DATA_with_dv", bus.P_DATA, 8'hA5);
        check_frame("t1", 1, 0, 0, 0, 8'hA5);

        // 2: Prescale 16, even parity, 0x37 good then bad parity.
        bus.Prescale = 6'd16;
        bus.PAR_TYP  = 1'b0;
        clear_counts();
        play(8'h37, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        check_frame("t2a", 1, 0, 0, 0, 8'h37);
        clear_counts();
        play(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 11);
        check_frame("t2b", 0, 1, 0, 0, 8'h37);

        // 3: start glitch at Prescale 8.
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        clear_counts();
        play(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check("t3_glitch_strobe", bus.strt_glitch, 1);
        check("t3_enable_dropped", bus.cnt_enable, 0);
        check_frame("t3", 0, 0, 0, 1, 8'h37);

        // 4: stop bit sampled 0.
        clear_counts();
        play(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        check_frame("t4", 0, 0, 1, 0, 8'h37);
`ifdef UART_RX_ERR_CNT_EN
        check("t4_par_err_cnt", bus.par_err_cnt, 1);
        check("t4_stp_err_cnt", bus.stp_err_cnt, 1);
`endif

        // 5: reset during data bit 4, then a clean 0x5A.
        play(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        for (int e = 1; e <= 3; e++) begin
            bus.bit_cnt  = 4'd4;
            bus.edge_cnt = 6'(e);
            next_cycle();
        end
        check("t5_busy_before_rst", bus.cnt_enable, 1);
        RST = 1'b0;
        #1;
        check("t5_rst_cnt_enable", bus.cnt_enable, 0);
        check("t5_rst_P_DATA", bus.P_DATA, 0);
        check("t5_rst_strobes", {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch}, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("t5_rst_err_cnts", {bus.par_err_cnt, bus.stp_err_cnt}, 0);
`endif
        bus.edge_cnt = 6'd1;
        bus.bit_cnt  = 4'd0;
        next_cycle();
        RST = 1'b1;
        next_cycle();
        clear_counts();
        play(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        check_frame("t5", 1, 0, 0, 0, 8'h5A);

        // 6: Prescale 32, odd parity, back-to-back 0x00 then 0xFF.
        bus.Prescale = 6'd32;
        bus.PAR_TYP  = 1'b1;
        clear_counts();
        play(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        check("t6a_dv", bus.data_valid, 1);
        check("t6a_P_DATA", bus.P_DATA, 8'h00);
        play(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        check("t6b_dv", bus.data_valid, 1);
        check("t6b_P_DATA", bus.P_DATA, 8'hFF);
        check_frame("t6", 2, 0, 0, 0, 8'hFF);
`ifdef UART_RX_ERR_CNT_EN
        check("t6_par_err_cnt", bus.par_err_cnt, 0);
        check("t6_stp_err_cnt", bus.stp_err_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
